// File: rtl/counter_mod_gen2.sv
// rtl/counter_mod_gen2.sv - programmable modulo up/down counter with wrap/saturate, tc pulse and sticky flags
module counter_mod_gen2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_n,
  input  logic [WIDTH-1:0] data_load,
  input  logic             ce,
  input  logic             up_down,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat_mode,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count_out,
  output logic             max_count,
  output logic             zero,
  output logic             tc_pulse,
  output logic             ovf_sticky,
  output logic             unf_sticky
);

  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic             ovf_q;
  logic             unf_q;

  logic [WIDTH-1:0] s_eff;
  logic [WIDTH:0]   lim_p1;
  logic [WIDTH:0]   sum_up;
  logic [WIDTH-1:0] wrap_up;
  logic [WIDTH-1:0] wrap_dn;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] next_count;
  logic             ovf_evt;
  logic             unf_evt;

  assign s_eff    = (step > limit) ? limit : step;
  assign load_val = (data_load > limit) ? limit : data_load;
  assign lim_p1   = {1'b0, limit} + {{WIDTH{1'b0}}, 1'b1};
  assign sum_up   = {1'b0, count_q} + {1'b0, s_eff};
  // Both wrap results fit in WIDTH bits because c and s never exceed limit here
  assign wrap_up  = WIDTH'(sum_up - lim_p1);
  assign wrap_dn  = WIDTH'({1'b0, count_q} + lim_p1 - {1'b0, s_eff});

  always_comb begin
    next_count = count_q;
    ovf_evt    = 1'b0;
    unf_evt    = 1'b0;
    if (count_q > limit) begin
      // Count stranded above a lowered limit: pull it back into range
      next_count = sat_mode ? limit : '0;
      ovf_evt    = 1'b1;
    end else if (s_eff != '0) begin
      if (up_down) begin
        if (sum_up <= {1'b0, limit}) begin
          next_count = sum_up[WIDTH-1:0];
        end else begin
          next_count = sat_mode ? limit : wrap_up;
          ovf_evt    = 1'b1;
        end
      end else begin
        if (count_q >= s_eff) begin
          next_count = count_q - s_eff;
        end else begin
          next_count = sat_mode ? '0 : wrap_dn;
          unf_evt    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tc_q  <= 1'b0;
      ovf_q <= ovf_q & ~clr_flags;
      unf_q <= unf_q & ~clr_flags;
      if (!load_n) begin
        count_q <= load_val;
      end else if (ce) begin
        count_q <= next_count;
        tc_q    <= ovf_evt | unf_evt;
        // A same-edge event overrides clr_flags
        if (ovf_evt) ovf_q <= 1'b1;
        if (unf_evt) unf_q <= 1'b1;
      end
    end
  end

  assign count_out  = count_q;
  assign max_count  = (count_q == limit);
  assign zero       = (count_q == '0);
  assign tc_pulse   = tc_q;
  assign ovf_sticky = ovf_q;
  assign unf_sticky = unf_q;

endmodule

// File: tb/tb_counter_mod_gen2.sv
// tb/tb_counter_mod_gen2.sv - directed self-checking bench for counter_mod_gen2
module tb_counter_mod_gen2;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_n;
  logic [WIDTH-1:0] data_load;
  logic             ce;
  logic             up_down;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] limit;
  logic             sat_mode;
  logic             clr_flags;
  logic [WIDTH-1:0] count_out;
  logic             max_count;
  logic             zero;
  logic             tc_pulse;
  logic             ovf_sticky;
  logic             unf_sticky;

  int total  = 0;
  int passed = 0;

  counter_mod_gen2 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .load_n(load_n), .data_load(data_load),
    .ce(ce), .up_down(up_down), .step(step), .limit(limit),
    .sat_mode(sat_mode), .clr_flags(clr_flags), .count_out(count_out),
    .max_count(max_count), .zero(zero), .tc_pulse(tc_pulse),
    .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int cnt, input bit tc, input bit ovf, input bit unf);
    check({tag, ".count"}, count_out, cnt);
    check({tag, ".tc"}, tc_pulse, tc);
    check({tag, ".ovf"}, ovf_sticky, ovf);
    check({tag, ".unf"}, unf_sticky, unf);
  endtask

  initial begin
    rst_n = 1'b0; load_n = 1'b1; data_load = '0; ce = 1'b0; up_down = 1'b1;
    step = '0; limit = 4'd9; sat_mode = 1'b0; clr_flags = 1'b0;
    #3;
    check_state("reset", 0, 0, 0, 0);
    check("reset.zero", zero, 1);
    check("reset.max", max_count, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Up wrap: 3,6,9,2
    step = 4'd3; ce = 1'b1;
    tick(); check_state("up1", 3, 0, 0, 0);
    tick(); check_state("up2", 6, 0, 0, 0);
    tick(); check_state("up3", 9, 0, 0, 0);
    check("up3.max", max_count, 1);
    tick(); check_state("up4", 2, 1, 1, 0);
    check("up4.max", max_count, 0);
    ce = 1'b0;
    tick(); check_state("hold", 2, 0, 1, 0);

    // Down saturate from 5 by 4; clr_flags on the load edge clears ovf
    step = 4'd4; sat_mode = 1'b1; load_n = 1'b0; data_load = 4'd5; clr_flags = 1'b1;
    tick(); check_state("ld5", 5, 0, 0, 0);
    load_n = 1'b1; clr_flags = 1'b0; up_down = 1'b0; ce = 1'b1;
    tick(); check_state("dn1", 1, 0, 0, 0);
    tick(); check_state("dn2", 0, 1, 0, 1);
    check("dn2.zero", zero, 1);
    tick(); check_state("dn3", 0, 1, 0, 1);
    ce = 1'b0;

    // Load clamps to limit; load beats count
    load_n = 1'b0; data_load = 4'd14;
    tick(); check_state("ld14", 9, 0, 0, 1);
    check("ld14.max", max_count, 1);
    ce = 1'b1; up_down = 1'b1; data_load = 4'd2;
    tick(); check_state("ldce", 2, 0, 0, 1);

    // Step clamp: limit 5, step 15, wrap, from 2 -> 1
    load_n = 1'b1; limit = 4'd5; step = 4'd15; sat_mode = 1'b0;
    tick(); check_state("clamp", 1, 1, 1, 1);

    // limit 0: no change, no event
    limit = 4'd0; load_n = 1'b0; data_load = 4'd0; clr_flags = 1'b1;
    tick(); check_state("lim0ld", 0, 0, 0, 0);
    load_n = 1'b1; clr_flags = 1'b0;
    tick(); check_state("lim0", 0, 0, 0, 0);
    check("lim0.zero", zero, 1);
    check("lim0.max", max_count, 1);

    // Limit lowered below count: out-of-range wrap to 0
    ce = 1'b0; limit = 4'd15; load_n = 1'b0; data_load = 4'd12;
    tick(); check_state("ld12", 12, 0, 0, 0);
    load_n = 1'b1; limit = 4'd7; step = 4'd1;
    #1 check("oor.nochg", count_out, 12);
    check("oor.max", max_count, 0);
    ce = 1'b1;
    tick(); check_state("oor", 0, 1, 1, 0);

    // clr_flags racing a new wrap: set wins
    ce = 1'b0; load_n = 1'b0; data_load = 4'd7;
    tick(); check_state("ld7", 7, 0, 1, 0);
    load_n = 1'b1; ce = 1'b1; clr_flags = 1'b1;
    tick(); check_state("race", 0, 1, 1, 0);
    ce = 1'b0;
    tick(); check_state("clr", 0, 0, 0, 0);
    clr_flags = 1'b0;

    // Reset mid-count at 7 with ovf set
    load_n = 1'b0; data_load = 4'd7;
    tick();
    load_n = 1'b1; ce = 1'b1;
    tick(); check_state("prewrap", 0, 1, 1, 0);
    limit = 4'd15; step = 4'd7;
    tick(); check_state("at7", 7, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1 check_state("arst", 0, 0, 0, 0);
    check("arst.zero", zero, 1);
    check("arst.max", max_count, 0);
    tick();
    rst_n = 1'b1; ce = 1'b0;
    tick(); check_state("post", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/counter_mod_gen2.md
Name: counter_mod_gen2

Overview:
- Second-generation parametrised up/down counter for the counter verification environment.
- Adds over the fixed-range counter: programmable modulo limit, programmable step, wrap or saturate mode, a terminal-count pulse and sticky overflow/underflow flags.
- Drives testbench stimulus generators and rate/timeout logic; one instance per channel.

Parameters:
WIDTH, 4, bit width of the count, step, limit and load value

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
load_n  input  1  synchronous active-low load of data_load
data_load  input  WIDTH  load value
ce  input  1  count enable
up_down  input  1  1 = count up, 0 = count down
step  input  WIDTH  increment/decrement magnitude
limit  input  WIDTH  maximum count value; legal range is 0..limit
sat_mode  input  1  1 = saturate at bounds, 0 = wrap modulo (limit+1)
clr_flags  input  1  synchronous clear of the sticky flags
count_out  output  WIDTH  registered count
max_count  output  1  count_out == limit (combinational from the register)
zero  output  1  count_out == 0 (combinational from the register)
tc_pulse  output  1  registered one-cycle pulse on a wrap or clip event
ovf_sticky  output  1  set on an up-wrap, up-clip or out-of-range event; held until cleared
unf_sticky  output  1  set on a down-wrap or down-clip event; held until cleared

Behaviour:
- Reset: rst_n low asynchronously forces count_out=0, tc_pulse=0, ovf_sticky=0 and unf_sticky=0, so zero=1 and max_count=(limit==0). Reset applies immediately, including mid-count.
- Priority per edge: reset > load (load_n=0) > count (ce=1) > hold. A load ignores ce and up_down.
- Load: count_out <= min(data_load, limit). A load never raises tc_pulse or any flag.
- Effective step: s = min(step, limit). step=0 or limit=0 means no change and no event.
- Out-of-range count (count_out > limit, possible after limit is lowered): a counting edge loads limit if sat_mode=1, otherwise 0. This sets ovf_sticky and pulses tc_pulse, regardless of up_down.
- Count up: compute c+s at WIDTH+1 bits.
  - If c+s <= limit, the result is c+s.
  - Otherwise, wrap mode gives c+s-(limit+1); saturate mode gives limit.
  - Either way the event sets ovf_sticky and pulses tc_pulse.
- Count down:
  - If c >= s, the result is c-s.
  - Otherwise, wrap mode gives c+(limit+1)-s; saturate mode gives 0.
  - Either way the event sets unf_sticky and pulses tc_pulse.
- Saturate hold: in saturate mode, already at a bound and pushing further with s>0 is a clip event every enabled cycle (count unchanged, tc_pulse high, flag set).
- tc_pulse timing: high for exactly the cycle in which the post-event count is first visible on count_out; low otherwise.
- clr_flags: clears both sticky flags on the edge. If an event occurs on the same edge, the set wins.
- Dynamic inputs: limit, step, sat_mode and up_down are sampled each edge with no registering. Changing limit never modifies count_out until the next load or count edge.
- No combinational path from inputs to count_out, tc_pulse or the sticky flags. max_count and zero depend on the register, and max_count also on limit.

Test Plan:
1. Reset mid-count: WIDTH=4, counting at 7, drop rst_n between edges -> count_out=0 immediately, zero=1, flags 0, tc_pulse 0.
2. Up wrap: limit=9, step=3, sat_mode=0, up, from 0 -> count_out 3,6,9,2. tc_pulse high only with 2; ovf_sticky=1; max_count=1 at 9.
3. Down saturate: limit=9, step=4, sat_mode=1, load 5, then down -> count_out 1,0,0. tc_pulse high on both 0 cycles; unf_sticky=1; zero=1.
4. Load: data_load=14, limit=9 -> count_out=9, max_count=1, no tc_pulse. Also load_n=0 with ce=1, up, data_load=2 -> count_out=2 (load wins).
5. Step clamp: limit=5, step=15, wrap, up, from 2 -> effective step 5, count_out=1, tc_pulse=1. Also limit=0 -> count stays 0, zero=max_count=1, no events.
6. Limit lowered and flag race: count 12, limit 15 -> 7, ce up wrap -> count_out=0, ovf_sticky=1. Then clr_flags=1 on the same edge as a new wrap -> ovf_sticky stays 1. Next clr_flags with no event -> 0.
